// File: rtl/cpu_pkg.sv
// Shared constants for the 4-bit CPU control path: opcodes, sequencer state
// encodings and ALU operation codes.
package cpu_pkg;

  localparam int DW_DEFAULT = 4;
  localparam int OPW        = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_FETCH   = 3'b001,
    ST_DECODE  = 3'b010,
    ST_OPFETCH = 3'b011,
    ST_EXEC    = 3'b100,
    ST_HALT    = 3'b101
  } state_t;

  localparam logic [OPW-1:0] OP_NOP  = 4'h0;
  localparam logic [OPW-1:0] OP_LDI  = 4'h1;
  localparam logic [OPW-1:0] OP_ADD  = 4'h2;
  localparam logic [OPW-1:0] OP_SUB  = 4'h3;
  localparam logic [OPW-1:0] OP_MOVB = 4'h4;
  localparam logic [OPW-1:0] OP_JMP  = 4'h5;
  localparam logic [OPW-1:0] OP_JZ   = 4'h6;
  localparam logic [OPW-1:0] OP_OUT  = 4'h7;
  localparam logic [OPW-1:0] OP_HLT  = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode classifier used by the sequencer while in DECODE.
module op_decode
  import cpu_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output logic           needs_operand,
  output logic           is_halt,
  output logic           legal
);

  always_comb begin
    needs_operand = 1'b0;
    is_halt       = 1'b0;
    legal         = 1'b0;
    case (opcode)
      OP_NOP, OP_ADD, OP_SUB, OP_MOVB, OP_OUT: legal = 1'b1;
      OP_LDI, OP_JMP, OP_JZ: begin
        legal         = 1'b1;
        needs_operand = 1'b1;
      end
      OP_HLT: begin
        legal   = 1'b1;
        is_halt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute sequencer for the 4-bit datapath; emits one-cycle
// register load/increment strobes decoded from the state and latched opcode.
module ctrl_sequencer
  import cpu_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          reg_clk,
  input  logic          reg_rst,
  input  logic          run,
  input  logic [DW-1:0] ir_data,
  input  logic          zero_flag,
  output logic          ir_en,
  output logic          pc_inc,
  output logic          pc_load,
  output logic          opr_en,
  output logic          a_en,
  output logic          b_en,
  output logic          a_src,
  output logic [1:0]    alu_op,
  output logic          out_en,
  output logic          halted,
  output logic          illegal,
  output logic [2:0]    state_dbg
);

  state_t        state_reg;
  logic [DW-1:0] op_q;
  logic          needs_operand;
  logic          is_halt;
  logic          legal;

  op_decode u_op_decode (
    .opcode        (ir_data[OPW-1:0]),
    .needs_operand (needs_operand),
    .is_halt       (is_halt),
    .legal         (legal)
  );

  always_ff @(posedge reg_clk) begin
    if (reg_rst) begin
      state_reg <= ST_IDLE;
      op_q      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE:    if (run) state_reg <= ST_FETCH;
        ST_FETCH:   state_reg <= ST_DECODE;
        ST_DECODE: begin
          op_q <= ir_data;
          if (is_halt)            state_reg <= ST_HALT;
          else if (needs_operand) state_reg <= ST_OPFETCH;
          else                    state_reg <= ST_EXEC;
        end
        ST_OPFETCH: state_reg <= ST_EXEC;
        ST_EXEC:    state_reg <= ST_FETCH;
        ST_HALT:    state_reg <= ST_HALT;
        // Unused encodings recover to IDLE rather than wedging the CPU.
        default:    state_reg <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ir_en   = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    opr_en  = 1'b0;
    a_en    = 1'b0;
    b_en    = 1'b0;
    a_src   = 1'b0;
    alu_op  = ALU_PASS;
    out_en  = 1'b0;
    halted  = 1'b0;
    illegal = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        ir_en  = 1'b1;
        pc_inc = 1'b1;
      end
      // IR was loaded at the FETCH edge, so its contents are valid here.
      ST_DECODE: illegal = ~legal;
      ST_OPFETCH: begin
        opr_en = 1'b1;
        pc_inc = 1'b1;
      end
      ST_EXEC: begin
        case (op_q[OPW-1:0])
          OP_LDI: begin
            a_en  = 1'b1;
            a_src = 1'b1;
          end
          OP_ADD: begin
            a_en   = 1'b1;
            alu_op = ALU_ADD;
          end
          OP_SUB: begin
            a_en   = 1'b1;
            alu_op = ALU_SUB;
          end
          OP_MOVB: b_en    = 1'b1;
          OP_JMP:  pc_load = 1'b1;
          OP_JZ:   pc_load = zero_flag;
          OP_OUT:  out_en  = 1'b1;
          default: ;
        endcase
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state_reg;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: walks reset, each opcode class, JZ both
// ways, an undefined opcode, reset during OPFETCH and the HALT state.
module tb_ctrl_sequencer;

  logic       reg_clk = 1'b0;
  logic       reg_rst;
  logic       run;
  logic [3:0] ir_data;
  logic       zero_flag;
  logic       ir_en, pc_inc, pc_load, opr_en, a_en, b_en, a_src;
  logic [1:0] alu_op;
  logic       out_en, halted, illegal;
  logic [2:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  // Strobe vector layout: {ir_en,pc_inc,pc_load,opr_en,a_en,b_en,a_src,alu_op,out_en,halted,illegal}
  localparam logic [11:0] S_NONE  = 12'h000;
  localparam logic [11:0] S_FETCH = 12'hC00;
  localparam logic [11:0] S_OPF   = 12'h500;
  localparam logic [11:0] S_LDI   = 12'h0A0;
  localparam logic [11:0] S_ADD   = 12'h088;
  localparam logic [11:0] S_SUB   = 12'h090;
  localparam logic [11:0] S_MOVB  = 12'h040;
  localparam logic [11:0] S_JMP   = 12'h200;
  localparam logic [11:0] S_OUT   = 12'h004;
  localparam logic [11:0] S_HALT  = 12'h002;
  localparam logic [11:0] S_ILL   = 12'h001;

  ctrl_sequencer #(.DW(4)) dut (
    .reg_clk   (reg_clk),
    .reg_rst   (reg_rst),
    .run       (run),
    .ir_data   (ir_data),
    .zero_flag (zero_flag),
    .ir_en     (ir_en),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .opr_en    (opr_en),
    .a_en      (a_en),
    .b_en      (b_en),
    .a_src     (a_src),
    .alu_op    (alu_op),
    .out_en    (out_en),
    .halted    (halted),
    .illegal   (illegal),
    .state_dbg (state_dbg)
  );

  always #5 reg_clk = ~reg_clk;

  task automatic step();
    @(posedge reg_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] es, input logic [11:0] ev);
    logic [11:0] got;
    got = {ir_en, pc_inc, pc_load, opr_en, a_en, b_en, a_src, alu_op, out_en, halted, illegal};
    checks++;
    assert ({state_dbg, got} === {es, ev})
    else begin
      failures++;
      $error("FAIL %s: observed state=%b strobes=%03h, expected state=%b strobes=%03h",
             tag, state_dbg, got, es, ev);
    end
    $display("step %-12s state=%b strobes=%03h", tag, state_dbg, got);
  endtask

  // Runs one instruction starting from a FETCH cycle and ending on the next FETCH.
  task automatic instr(input string tag, input logic [3:0] op, input logic multi,
                       input logic [11:0] dec_exp, input logic [11:0] exec_exp);
    chk({tag, "_fetch"}, 3'b001, S_FETCH);
    ir_data = op;
    step();
    chk({tag, "_dec"}, 3'b010, dec_exp);
    if (multi) begin
      step();
      chk({tag, "_opf"}, 3'b011, S_OPF);
    end
    step();
    chk({tag, "_exec"}, 3'b100, exec_exp);
    step();
  endtask

  initial begin
    reg_rst   = 1'b1;
    run       = 1'b1;
    ir_data   = 4'h0;
    zero_flag = 1'b0;
    step();
    step();
    chk("reset", 3'b000, S_NONE);

    reg_rst = 1'b0;
    step();
    run = 1'b0;  // execution must continue once started
    instr("nop0", 4'h0, 1'b0, S_NONE, S_NONE);
    instr("nop1", 4'h0, 1'b0, S_NONE, S_NONE);
    instr("ldi",  4'h1, 1'b1, S_NONE, S_LDI);
    instr("add",  4'h2, 1'b0, S_NONE, S_ADD);
    instr("sub",  4'h3, 1'b0, S_NONE, S_SUB);
    instr("movb", 4'h4, 1'b0, S_NONE, S_MOVB);
    instr("out",  4'h7, 1'b0, S_NONE, S_OUT);
    instr("jmp",  4'h5, 1'b1, S_NONE, S_JMP);
    zero_flag = 1'b0;
    instr("jz0",  4'h6, 1'b1, S_NONE, S_NONE);
    zero_flag = 1'b1;
    instr("jz1",  4'h6, 1'b1, S_NONE, S_JMP);
    zero_flag = 1'b0;
    instr("undef9", 4'h9, 1'b0, S_ILL, S_NONE);
    instr("undefE", 4'hE, 1'b0, S_ILL, S_NONE);

    // Abort an LDI while its operand is being fetched.
    chk("abort_fetch", 3'b001, S_FETCH);
    ir_data = 4'h1;
    step();
    chk("abort_dec", 3'b010, S_NONE);
    step();
    chk("abort_opf", 3'b011, S_OPF);
    reg_rst = 1'b1;
    step();
    chk("abort_rst", 3'b000, S_NONE);
    reg_rst = 1'b0;
    step();
    chk("abort_idle", 3'b000, S_NONE);
    step();
    chk("abort_idle2", 3'b000, S_NONE);

    run = 1'b1;
    step();
    chk("hlt_fetch", 3'b001, S_FETCH);
    ir_data = 4'hF;
    step();
    chk("hlt_dec", 3'b010, S_NONE);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("halt_hold", 3'b101, S_HALT);
      run = ~run;
    end

    reg_rst = 1'b1;
    step();
    chk("halt_rst", 3'b000, S_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
